// File: rtl/main_job_arbiter_if.sv
// Requester-side and compute-unit-side signals of the job arbiter.
// master = arbiter, slave = requesters plus compute unit.
interface main_job_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_x;
  logic [2*NREQ-1:0] req_mode;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        res_y;
  logic              res_err;
  logic [IDW-1:0]    cur_id;
  logic              busy;
  logic [7:0]        unit_x;
  logic [1:0]        unit_on;
  logic              unit_start;
  logic [7:0]        unit_y;
  logic              unit_b;

  modport master (
    input  req, req_x, req_mode,
    input  unit_y, unit_b,
    output gnt, done, res_y, res_err,
    output cur_id, busy,
    output unit_x, unit_on, unit_start
  );

  modport slave (
    output req, req_x, req_mode,
    output unit_y, unit_b,
    input  gnt, done, res_y, res_err,
    input  cur_id, busy,
    input  unit_x, unit_on, unit_start
  );
endinterface

// File: rtl/main_job_arbiter.sv
// Round-robin sharing of one compute unit among NREQ requesters,
// one job in flight, with ack and run watchdogs.
module main_job_arbiter #(
  parameter int NREQ   = 4,
  parameter int ACK_TO = 4,
  parameter int RUN_TO = 64
) (
  input  logic clk,
  input  logic rst,
  main_job_arbiter_if.master bus
);
  localparam int IDW  = $clog2(NREQ);
  localparam int TMAX = (ACK_TO > RUN_TO) ? ACK_TO : RUN_TO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      res_y_q, res_y_d;
  logic            res_err_q, res_err_d;
  logic            busy_q, busy_d;
  logic [7:0]      unit_x_q, unit_x_d;
  logic [1:0]      unit_on_q, unit_on_d;
  logic            unit_start_q, unit_start_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_id;

  function automatic logic [IDW-1:0] wrap_add(
    input logic [IDW-1:0] a,
    input int             k
  );
    int s;
    s = int'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First requester at or above ptr, wrapping modulo NREQ
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && bus.req[wrap_add(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_id  = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cur_id_d     = cur_id_q;
    tmr_d        = tmr_q;
    gnt_d        = '0;
    done_d       = '0;
    res_y_d      = res_y_q;
    res_err_d    = res_err_q;
    busy_d       = busy_q;
    unit_x_d     = unit_x_q;
    unit_on_d    = unit_on_q;
    unit_start_d = unit_start_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          unit_x_d       = bus.req_x[8*int'(pick_id) +: 8];
          unit_on_d      = bus.req_mode[2*int'(pick_id) +: 2];
          cur_id_d       = pick_id;
          gnt_d[pick_id] = 1'b1;
          busy_d         = 1'b1;
          unit_start_d   = 1'b1;
          tmr_d          = '0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.unit_b) begin
          unit_start_d = 1'b0;
          tmr_d        = '0;
          state_d      = S_RUN;
        end else if (tmr_q == TW'(ACK_TO - 1)) begin
          unit_start_d     = 1'b0;
          res_y_d          = '0;
          res_err_d        = 1'b1;
          done_d[cur_id_q] = 1'b1;
          tmr_d            = '0;
          state_d          = S_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.unit_b) begin
          res_y_d          = bus.unit_y;
          res_err_d        = 1'b0;
          done_d[cur_id_q] = 1'b1;
          tmr_d            = '0;
          state_d          = S_RESP;
        end else if (tmr_q == TW'(RUN_TO - 1)) begin
          res_y_d          = '0;
          res_err_d        = 1'b1;
          done_d[cur_id_q] = 1'b1;
          tmr_d            = '0;
          state_d          = S_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = wrap_add(cur_id_q, 1);
        busy_d  = 1'b0;
        tmr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cur_id_q     <= '0;
      tmr_q        <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      res_y_q      <= '0;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      unit_x_q     <= '0;
      unit_on_q    <= '0;
      unit_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_id_q     <= cur_id_d;
      tmr_q        <= tmr_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      res_y_q      <= res_y_d;
      res_err_q    <= res_err_d;
      busy_q       <= busy_d;
      unit_x_q     <= unit_x_d;
      unit_on_q    <= unit_on_d;
      unit_start_q <= unit_start_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.res_y      = res_y_q;
  assign bus.res_err    = res_err_q;
  assign bus.cur_id     = cur_id_q;
  assign bus.busy       = busy_q;
  assign bus.unit_x     = unit_x_q;
  assign bus.unit_on    = unit_on_q;
  assign bus.unit_start = unit_start_q;
endmodule
